elevator_scheduler: RTL and testbench
=====================================

// Module: elevator_scheduler
// PURPOSE
// - Clocked car scheduler for the 4-floor elevator: latches hall calls (up/down) and car calls,
//   chooses travel direction (collective/SCAN), times floor-to-floor travel and door dwell.
// - Drives current floor, direction, motor and door outputs; its pending vectors feed floor-lamp logic.
// PARAMETERS
// N_FLOORS       4    number of floors; floor 0 is lowest
// FLOOR_W        2    width of floor index, clog2(N_FLOORS)
// TRAVEL_CYCLES  8    clock cycles to move one floor (>=2)
// DOOR_CYCLES    16   clock cycles the door stays open (>=2)
// PORTS
// clk           in   1         system clock
// reset         in   1         synchronous, active-high reset
// hall_up_req   in   N_FLOORS  1-cycle pulses; bit f = up call at floor f (bit N-1 ignored)
// hall_dn_req   in   N_FLOORS  1-cycle pulses; bit f = down call at floor f (bit 0 ignored)
// car_req       in   N_FLOORS  1-cycle pulses; bit f = destination f from car panel
// door_hold     in   1         level; while 1 and door open, dwell timer reloads
// current_floor out  FLOOR_W   floor the car is at / last passed
// dir_up        out  1         1 = up, 0 = down (current or last direction)
// moving        out  1         1 while state = MOVE
// door_open     out  1         1 while state = DOOR
// arrive        out  1         1-cycle pulse when current_floor changes
// up_pend       out  N_FLOORS  latched up calls
// dn_pend       out  N_FLOORS  latched down calls
// car_pend      out  N_FLOORS  latched car calls
// BEHAVIOUR
// - Reset: state IDLE, current_floor=0, dir_up=1, moving=0, door_open=0, arrive=0, all pend=0.
//   Reset mid-MOVE/DOOR aborts immediately; car is logically at floor 0 next cycle. Reset wins over requests.
// - Latching: pend[f] <= pend[f] | req[f] every cycle unless cleared by a stop that same cycle;
//   a request arriving in the same cycle as its clear is NOT latched (absorbed by that stop).
// - In DOOR at floor f: car_req[f], or hall call at f in dir_up direction, is absorbed (not latched)
//   and reloads the dwell timer. Opposite-direction hall call at f is latched normally.
// - "ahead" = any pend bit strictly above f (dir_up=1) or below f (dir_up=0); "behind" likewise reversed.
// - IDLE (1-cycle decision, outputs idle):
//   1) any pend at current floor -> DOOR; clear car_pend[f], up_pend[f], dn_pend[f]; set dir_up to
//      direction of a cleared hall call if exactly one, else keep.
//   2) else pend ahead -> MOVE, keep dir_up; else pend behind -> MOVE, flip dir_up.
//   3) else stay IDLE.
// - MOVE: travel counter loads TRAVEL_CYCLES-1 on entry, decrements; at 0: current_floor +/-1,
//   arrive=1 that cycle, then stop test at new floor f:
//   stop if car_pend[f] | (dir_up ? up_pend[f] : dn_pend[f]) | no pend ahead of f.
//   On stop -> DOOR; clear car_pend[f] and same-direction hall bit; if nothing ahead also clear
//   opposite hall bit and flip dir_up. Else reload counter, stay MOVE.
//   Floors 0 and N-1 always have nothing ahead, so car never leaves range.
// - DOOR: dwell counter loads DOOR_CYCLES-1 on entry, decrements; door_hold or absorbed request
//   reloads it; at 0 -> IDLE (door_open drops that edge). Minimum door time DOOR_CYCLES cycles.
// - Latency: request pulse -> pend bit visible next cycle; IDLE -> moving=1 one cycle after decision.
// - Outputs are registered; no combinational path input->output.
// TESTING
// 1) reset; car_req=4'b1000 pulse -> after 1 cycle IDLE->MOVE, dir_up=1; arrive at floors 1,2,3
//    spaced 8 cycles; door_open=1 at floor 3 for 16 cycles; car_pend=0.
// 2) at floor 0, hall_dn_req[2] and car_req[3] pulsed -> car passes 2 (up, no stop), stops 3,
//    flips dir_up=0, then stops at 2 clearing dn_pend[2].
// 3) door open at floor 1 going up, hall_up_req[1] every 10 cycles x3 -> door stays open,
//    up_pend[1] never set; door_hold=1 for 40 cycles -> door_open held 40+ cycles.
// 4) requests bit-for-bit on hall_up_req[3] and hall_dn_req[0] only -> pend stays 0, car stays IDLE.
// 5) assert reset 3 cycles into MOVE from floor 2 toward 3 -> next cycle current_floor=0,
//    moving=0, all pend=0; no arrive pulse.
// 6) idle at floor 1, dir_up=1, pend at 0 and 3 same cycle -> goes up first (keeps dir_up).

Source files
------------

// File: rtl/elevator_scheduler.sv
// Car scheduler for a small elevator. It latches hall and car calls, chooses the
// travel direction by collective (SCAN) control, and times floor-to-floor travel
// and door dwell.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   hall_up_req     1-cycle up-call pulses per floor (top floor bit ignored)
//   hall_dn_req     1-cycle down-call pulses per floor (floor 0 bit ignored)
//   car_req         1-cycle destination pulses from the car panel
//   door_hold       level; keeps an open door open
//   current_floor   floor the car is at or last passed
//   dir_up          current or last travel direction (1 = up)
//   moving          car travelling between floors
//   door_open       door open at current_floor
//   arrive          1-cycle pulse when current_floor changes
//   up_pend, dn_pend, car_pend  latched calls, for the floor lamps
module elevator_scheduler #(
  parameter int unsigned N_FLOORS      = 4,
  parameter int unsigned FLOOR_W       = 2,
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] hall_up_req,
  input  logic [N_FLOORS-1:0] hall_dn_req,
  input  logic [N_FLOORS-1:0] car_req,
  input  logic                door_hold,
  output logic [FLOOR_W-1:0]  current_floor,
  output logic                dir_up,
  output logic                moving,
  output logic                door_open,
  output logic                arrive,
  output logic [N_FLOORS-1:0] up_pend,
  output logic [N_FLOORS-1:0] dn_pend,
  output logic [N_FLOORS-1:0] car_pend
);

  localparam int unsigned CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);

  // No up call exists at the top floor and no down call at floor 0.
  localparam logic [N_FLOORS-1:0] UP_MASK = ~(N_FLOORS'(1) << (N_FLOORS - 1));
  localparam logic [N_FLOORS-1:0] DN_MASK = ~N_FLOORS'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MOVE = 2'd1;
  localparam logic [1:0] S_DOOR = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [FLOOR_W-1:0]  floor_q, floor_d;
  logic                dir_q, dir_d;
  logic                arrive_q, arrive_d;
  logic                moving_q, door_open_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_FLOORS-1:0] up_pend_q, up_pend_d;
  logic [N_FLOORS-1:0] dn_pend_q, dn_pend_d;
  logic [N_FLOORS-1:0] car_pend_q, car_pend_d;

  logic [N_FLOORS-1:0] clr_up, clr_dn, clr_car;
  logic [N_FLOORS-1:0] all_pend, cur_oh, nxt_oh;
  logic [FLOOR_W-1:0]  nxt_floor;
  logic                more_ahead, absorb;

  // Any pending call strictly above (up=1) or strictly below (up=0) floor f.
  function automatic logic pend_ahead(input logic [N_FLOORS-1:0] p,
                                      input logic [FLOOR_W-1:0]  f,
                                      input logic                up);
    logic [N_FLOORS-1:0] below, at_or_below;
    below       = (N_FLOORS'(1) << f) - N_FLOORS'(1);
    at_or_below = below | (N_FLOORS'(1) << f);
    return up ? |(p & ~at_or_below) : |(p & below);
  endfunction

  // Next-state logic: direction choice, travel/dwell timing and call clearing.
  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    arrive_d   = 1'b0;
    clr_up     = '0;
    clr_dn     = '0;
    clr_car    = '0;
    more_ahead = 1'b0;
    absorb     = 1'b0;
    all_pend   = up_pend_q | dn_pend_q | car_pend_q;
    nxt_floor  = dir_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    cur_oh     = N_FLOORS'(1) << floor_q;
    nxt_oh     = N_FLOORS'(1) << nxt_floor;

    case (state_q)
      S_IDLE: begin
        if (|(all_pend & cur_oh)) begin
          state_d = S_DOOR;
          cnt_d   = DOOR_LOAD;
          clr_up  = cur_oh;
          clr_dn  = cur_oh;
          clr_car = cur_oh;
          // A lone hall call at this floor decides which way the car will serve.
          if (|(up_pend_q & cur_oh) != |(dn_pend_q & cur_oh))
            dir_d = |(up_pend_q & cur_oh);
        end else if (pend_ahead(all_pend, floor_q, dir_q)) begin
          state_d = S_MOVE;
          cnt_d   = TRAVEL_LOAD;
        end else if (pend_ahead(all_pend, floor_q, ~dir_q)) begin
          state_d = S_MOVE;
          cnt_d   = TRAVEL_LOAD;
          dir_d   = ~dir_q;
        end
      end

      S_MOVE: begin
        if (cnt_q == '0) begin
          floor_d    = nxt_floor;
          arrive_d   = 1'b1;
          more_ahead = pend_ahead(all_pend, nxt_floor, dir_q);
          if (|(car_pend_q & nxt_oh) || |((dir_q ? up_pend_q : dn_pend_q) & nxt_oh) || !more_ahead) begin
            state_d = S_DOOR;
            cnt_d   = DOOR_LOAD;
            clr_car = nxt_oh;
            if (dir_q) clr_up = nxt_oh;
            else       clr_dn = nxt_oh;
            // End of run: serve the opposite call here too and turn around.
            if (!more_ahead) begin
              if (dir_q) clr_dn = nxt_oh;
              else       clr_up = nxt_oh;
              dir_d = ~dir_q;
            end
          end else begin
            cnt_d = TRAVEL_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DOOR: begin
        // Car and same-direction calls at the open door are served by it.
        absorb  = |((car_req | (dir_q ? (hall_up_req & UP_MASK) : (hall_dn_req & DN_MASK))) & cur_oh);
        clr_car = cur_oh;
        if (dir_q) clr_up = cur_oh;
        else       clr_dn = cur_oh;
        if (door_hold || absorb)   cnt_d = DOOR_LOAD;
        else if (cnt_q == '0)      state_d = S_IDLE;
        else                       cnt_d = cnt_q - CNT_W'(1);
      end

      default: state_d = S_IDLE;
    endcase

    up_pend_d  = (up_pend_q  | (hall_up_req & UP_MASK)) & ~clr_up;
    dn_pend_d  = (dn_pend_q  | (hall_dn_req & DN_MASK)) & ~clr_dn;
    car_pend_d = (car_pend_q | car_req) & ~clr_car;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      floor_q     <= '0;
      dir_q       <= 1'b1;
      arrive_q    <= 1'b0;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
      cnt_q       <= '0;
      up_pend_q   <= '0;
      dn_pend_q   <= '0;
      car_pend_q  <= '0;
    end else begin
      state_q     <= state_d;
      floor_q     <= floor_d;
      dir_q       <= dir_d;
      arrive_q    <= arrive_d;
      moving_q    <= (state_d == S_MOVE);
      door_open_q <= (state_d == S_DOOR);
      cnt_q       <= cnt_d;
      up_pend_q   <= up_pend_d;
      dn_pend_q   <= dn_pend_d;
      car_pend_q  <= car_pend_d;
    end
  end

  assign current_floor = floor_q;
  assign dir_up        = dir_q;
  assign moving        = moving_q;
  assign door_open     = door_open_q;
  assign arrive        = arrive_q;
  assign up_pend       = up_pend_q;
  assign dn_pend       = dn_pend_q;
  assign car_pend      = car_pend_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed scenarios with constant expectations,
// then randomized traffic checked against a behavioural car model.
module tb_elevator_scheduler;
  localparam int N      = 4;
  localparam int TRAVEL = 8;
  localparam int DOOR   = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] hall_up_req = '0, hall_dn_req = '0, car_req = '0;
  logic       door_hold = 1'b0;
  logic [1:0] current_floor;
  logic       dir_up, moving, door_open, arrive;
  logic [3:0] up_pend, dn_pend, car_pend;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  elevator_scheduler #(.N_FLOORS(4), .FLOOR_W(2), .TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)) dut (
    .clk(clk), .reset(reset), .hall_up_req(hall_up_req), .hall_dn_req(hall_dn_req),
    .car_req(car_req), .door_hold(door_hold), .current_floor(current_floor),
    .dir_up(dir_up), .moving(moving), .door_open(door_open), .arrive(arrive),
    .up_pend(up_pend), .dn_pend(dn_pend), .car_pend(car_pend));

  // Behavioural car: mode 0 = waiting, 1 = travelling, 2 = door open.
  int m_mode = 0;
  int m_floor = 0;
  int m_timer = 0;
  bit m_dir = 1'b1;
  bit m_arrive = 1'b0;
  bit m_up [N];
  bit m_dn [N];
  bit m_car [N];

  function automatic bit m_any(int from, bit upward);
    for (int i = 0; i < N; i++)
      if ((upward ? (i > from) : (i < from)) && (m_up[i] || m_dn[i] || m_car[i])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [17:0] m_vec();
    logic [3:0] u, d, c;
    for (int i = 0; i < N; i++) begin
      u[i] = m_up[i]; d[i] = m_dn[i]; c[i] = m_car[i];
    end
    return {2'(m_floor), m_dir, m_mode == 1, m_mode == 2, m_arrive, u, d, c};
  endfunction

  task automatic model_step(input bit rst, input logic [3:0] hu, input logic [3:0] hd,
                            input logic [3:0] cr, input bit hold);
    bit cu [N];
    bit cd [N];
    bit cc [N];
    int f, nf;
    bit beyond, absorbed;
    for (int i = 0; i < N; i++) begin cu[i] = 0; cd[i] = 0; cc[i] = 0; end
    if (rst) begin
      m_mode = 0; m_floor = 0; m_dir = 1; m_arrive = 0; m_timer = 0;
      for (int i = 0; i < N; i++) begin m_up[i] = 0; m_dn[i] = 0; m_car[i] = 0; end
      return;
    end
    m_arrive = 0;
    f = m_floor;
    case (m_mode)
      0: begin
        if (m_up[f] || m_dn[f] || m_car[f]) begin
          if (m_up[f] != m_dn[f]) m_dir = m_up[f];
          cu[f] = 1; cd[f] = 1; cc[f] = 1;
          m_mode = 2; m_timer = DOOR;
        end else if (m_any(f, m_dir)) begin
          m_mode = 1; m_timer = TRAVEL;
        end else if (m_any(f, !m_dir)) begin
          m_dir = !m_dir; m_mode = 1; m_timer = TRAVEL;
        end
      end
      1: begin
        m_timer = m_timer - 1;
        if (m_timer == 0) begin
          nf = m_dir ? f + 1 : f - 1;
          beyond = m_any(nf, m_dir);
          m_floor = nf;
          m_arrive = 1;
          if (m_car[nf] || (m_dir ? m_up[nf] : m_dn[nf]) || !beyond) begin
            cc[nf] = 1;
            if (m_dir) cu[nf] = 1; else cd[nf] = 1;
            if (!beyond) begin
              if (m_dir) cd[nf] = 1; else cu[nf] = 1;
              m_dir = !m_dir;
            end
            m_mode = 2; m_timer = DOOR;
          end else begin
            m_timer = TRAVEL;
          end
        end
      end
      default: begin
        absorbed = 0;
        if (cr[f]) begin cc[f] = 1; absorbed = 1; end
        if (m_dir && hu[f] && f != N - 1) begin cu[f] = 1; absorbed = 1; end
        if (!m_dir && hd[f] && f != 0) begin cd[f] = 1; absorbed = 1; end
        if (hold || absorbed) m_timer = DOOR;
        else begin
          m_timer = m_timer - 1;
          if (m_timer == 0) m_mode = 0;
        end
      end
    endcase
    for (int i = 0; i < N; i++) begin
      m_up[i]  = (m_up[i]  || (hu[i] && i != N - 1)) && !cu[i];
      m_dn[i]  = (m_dn[i]  || (hd[i] && i != 0))     && !cd[i];
      m_car[i] = (m_car[i] || cr[i]) && !cc[i];
    end
  endtask

  // One clock: drive inputs, clock edge, advance model, sample point at +1.
  task automatic cyc(input bit rst, input logic [3:0] hu, input logic [3:0] hd,
                     input logic [3:0] cr, input bit hold);
    reset = rst; hall_up_req = hu; hall_dn_req = hd; car_req = cr; door_hold = hold;
    @(posedge clk);
    model_step(rst, hu, hd, cr, hold);
    #1;
    reset = 0; hall_up_req = '0; hall_dn_req = '0; car_req = '0;
  endtask

  task automatic test_reset();
    cyc(1, 4'b0111, 4'b1110, 4'b1111, 1);
    cyc(1, 4'b0011, 4'b0110, 4'b0101, 0);
    n_tests++;
    if ({current_floor, dir_up, moving, door_open, arrive} !== 6'b001000) begin
      n_fail++; $display("FAIL reset_state: got %b want 001000", {current_floor, dir_up, moving, door_open, arrive});
    end
    n_tests++;
    if ({up_pend, dn_pend, car_pend} !== 12'h000) begin
      n_fail++; $display("FAIL reset_pend: got %h want 000", {up_pend, dn_pend, car_pend});
    end
    repeat (3) cyc(0, 0, 0, 0, 0);
    n_tests++;
    if ({moving, door_open, current_floor} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_idle: got %b want 0000", {moving, door_open, current_floor});
    end
  endtask

  task automatic test_run_up();
    int arr_t [4];
    int arr_f [4];
    int n_arr = 0, door_cnt = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 4'b1000, 0);
    n_tests++;
    if ({car_pend, moving} !== 5'b10000) begin
      n_fail++; $display("FAIL runup_latch: got %b want 10000", {car_pend, moving});
    end
    cyc(0, 0, 0, 0, 0);
    n_tests++;
    if ({moving, dir_up} !== 2'b11) begin
      n_fail++; $display("FAIL runup_start: got %b want 11", {moving, dir_up});
    end
    for (int t = 1; t <= 60; t++) begin
      cyc(0, 0, 0, 0, 0);
      if (arrive && n_arr < 4) begin arr_t[n_arr] = t; arr_f[n_arr] = int'(current_floor); n_arr++; end
      if (door_open) door_cnt++;
    end
    n_tests++;
    if (n_arr !== 3) begin n_fail++; $display("FAIL runup_arrivals: got %0d want 3", n_arr); end
    for (int k = 0; k < 3 && k < n_arr; k++) begin
      n_tests++;
      if (arr_t[k] !== 8 * (k + 1) || arr_f[k] !== k + 1) begin
        n_fail++; $display("FAIL runup_arrive%0d: got t=%0d f=%0d want t=%0d f=%0d", k, arr_t[k], arr_f[k], 8 * (k + 1), k + 1);
      end
    end
    n_tests++;
    if (door_cnt !== DOOR) begin n_fail++; $display("FAIL runup_door_time: got %0d want %0d", door_cnt, DOOR); end
    n_tests++;
    if ({car_pend, current_floor, dir_up} !== 7'b0000110) begin
      n_fail++; $display("FAIL runup_end: got %b want 0000110", {car_pend, current_floor, dir_up});
    end
  endtask

  task automatic test_pass_through();
    int exp_f [4] = '{1, 2, 3, 2};
    bit exp_d [4] = '{0, 0, 1, 1};
    int got_f [4];
    bit got_d [4];
    bit dir_at3 = 1'b1;
    int n_arr = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 4'b0100, 4'b1000, 0);
    for (int t = 0; t < 120; t++) begin
      cyc(0, 0, 0, 0, 0);
      if (arrive && n_arr < 4) begin
        got_f[n_arr] = int'(current_floor); got_d[n_arr] = door_open;
        if (current_floor == 2'd3) dir_at3 = dir_up;
        n_arr++;
      end
    end
    n_tests++;
    if (n_arr !== 4) begin n_fail++; $display("FAIL pass_arrivals: got %0d want 4", n_arr); end
    for (int k = 0; k < 4 && k < n_arr; k++) begin
      n_tests++;
      if (got_f[k] !== exp_f[k] || got_d[k] !== exp_d[k]) begin
        n_fail++; $display("FAIL pass_stop%0d: got f=%0d door=%0d want f=%0d door=%0d", k, got_f[k], got_d[k], exp_f[k], exp_d[k]);
      end
    end
    n_tests++;
    if (dir_at3 !== 1'b0) begin n_fail++; $display("FAIL pass_flip_at_top: got %0d want 0", dir_at3); end
    n_tests++;
    if ({up_pend, dn_pend, car_pend} !== 12'h000) begin
      n_fail++; $display("FAIL pass_cleared: got %h want 000", {up_pend, dn_pend, car_pend});
    end
  endtask

  task automatic test_door_absorb();
    bit found = 0;
    int bad = 0, open_cnt = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 4'b1010, 0);
    for (int t = 0; t < 40 && !found; t++) begin
      cyc(0, 0, 0, 0, 0);
      if (door_open) found = 1;
    end
    n_tests++;
    if ({found, current_floor, dir_up} !== 4'b1011) begin
      n_fail++; $display("FAIL absorb_reach: got %b want 1011", {found, current_floor, dir_up});
    end
    for (int k = 0; k < 30; k++) begin
      cyc(0, (k % 10 == 0) ? 4'b0010 : 4'b0000, 0, 0, 0);
      if (door_open !== 1'b1 || up_pend[1] !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL absorb_hall_up: got %0d bad cycles want 0", bad); end
    for (int k = 0; k < 40; k++) begin
      cyc(0, 0, 0, 0, 1);
      if (door_open !== 1'b1) bad++;
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL absorb_hold: got %0d closed cycles want 0", bad); end
    for (int k = 0; k < 20; k++) begin
      cyc(0, 0, 0, 0, 0);
      if (door_open) open_cnt++;
    end
    n_tests++;
    if (open_cnt !== DOOR - 1) begin n_fail++; $display("FAIL absorb_release: got %0d want %0d", open_cnt, DOOR - 1); end
  endtask

  task automatic test_ignored_bits();
    int bad = 0;
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      cyc(0, (k % 2 == 0) ? 4'b1000 : 4'b0000, (k % 3 == 0) ? 4'b0001 : 4'b0000, 0, 0);
      if ({up_pend, dn_pend, car_pend, moving, door_open} !== 14'h0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL ignored_bits: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_reset_mid_move();
    bit found = 0, seen_arrive = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 4'b1100, 0);
    for (int t = 0; t < 100 && !found; t++) begin
      cyc(0, 0, 0, 0, 0);
      if (moving && current_floor == 2'd2) found = 1;
    end
    n_tests++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL midmove_reach: got %0d want 1", found); end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 4'b0111, 4'b1110, 4'b1111, 0);
    n_tests++;
    if ({current_floor, dir_up, moving, door_open, arrive, up_pend, dn_pend, car_pend} !== 18'b00_1_0_0_0_0000_0000_0000) begin
      n_fail++; $display("FAIL midmove_reset: got %b want 001000000000000000",
                         {current_floor, dir_up, moving, door_open, arrive, up_pend, dn_pend, car_pend});
    end
    for (int k = 0; k < 12; k++) begin
      cyc(0, 0, 0, 0, 0);
      if (arrive || moving) seen_arrive = 1;
    end
    n_tests++;
    if (seen_arrive !== 1'b0) begin n_fail++; $display("FAIL midmove_quiet: got %0d want 0", seen_arrive); end
  endtask

  task automatic test_idle_prefers_dir();
    bit found = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 4'b0010, 0);
    for (int t = 0; t < 40 && !found; t++) begin cyc(0, 0, 0, 0, 0); if (door_open) found = 1; end
    for (int t = 0; t < 40 && door_open; t++) cyc(0, 0, 0, 0, 0);
    n_tests++;
    if ({found, current_floor, dir_up, door_open} !== 5'b10100) begin
      n_fail++; $display("FAIL pref_first_stop: got %b want 10100", {found, current_floor, dir_up, door_open});
    end
    cyc(0, 4'b0010, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    n_tests++;
    if ({door_open, dir_up, up_pend} !== 6'b110000) begin
      n_fail++; $display("FAIL pref_set_dir: got %b want 110000", {door_open, dir_up, up_pend});
    end
    for (int t = 0; t < 40 && door_open; t++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 4'b1001, 0);
    found = 0;
    for (int t = 0; t < 30 && !found; t++) begin cyc(0, 0, 0, 0, 0); if (arrive) found = 1; end
    n_tests++;
    if ({found, current_floor, dir_up} !== 4'b1101) begin
      n_fail++; $display("FAIL pref_goes_up: got %b want 1101", {found, current_floor, dir_up});
    end
  endtask

  task automatic test_random();
    int hold_left = 0, shown = 0;
    logic [3:0] hu, hd, cr;
    bit hold, rst;
    logic [17:0] got, exp;
    cyc(1, 0, 0, 0, 0);
    for (int c = 0; c < 4000; c++) begin
      hu = ($urandom_range(0, 9) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      hd = ($urandom_range(0, 9) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      cr = ($urandom_range(0, 7) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      if (hold_left > 0) begin hold = 1; hold_left--; end
      else begin hold = 0; if ($urandom_range(0, 99) == 0) hold_left = int'($urandom_range(1, 30)); end
      rst = ($urandom_range(0, 999) == 0);
      cyc(rst, hu, hd, cr, hold);
      got = {current_floor, dir_up, moving, door_open, arrive, up_pend, dn_pend, car_pend};
      exp = m_vec();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        if (shown < 10) begin
          shown++; $display("FAIL random_c%0d: got %b want %b", c, got, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_up();
    test_pass_through();
    test_door_absorb();
    test_ignored_bits();
    test_reset_mid_move();
    test_idle_prefers_dir();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
